// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore sequencer with memory wait handshake, timeout trap,
// sticky error code and retired-instruction counter. Handshake/timeout logic exists only with MEM_HANDSHAKE_EN.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic [3:0]           state,
  output logic [1:0]           err,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e               state_q, state_d;
  logic [1:0]           err_q, err_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 adr_src_q, adr_src_d;
  logic [1:0]           alu_src_a_q, alu_src_a_d;
  logic [1:0]           alu_src_b_q, alu_src_b_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [2:0]           alu_ctrl_q, alu_ctrl_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_write_q, mem_write_d;
  logic                 ready_s;
  logic                 tmo_hit_s;
  logic                 retire_s;
  logic [2:0]           funct_alu_s;

`ifdef MEM_HANDSHAKE_EN
  localparam int TmoW = $clog2(MEM_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            mem_state_s;
  logic            enter_mem_s;

  assign ready_s     = mem_ready;
  assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign enter_mem_s = (state_d != state_q) &&
                       ((state_d == S_FETCH) || (state_d == S_MEMREAD) || (state_d == S_MEMWRITE));
  assign tmo_hit_s   = !mem_ready && (tmo_q == TmoW'(MEM_TIMEOUT - 1));

  // Consecutive not-ready cycles within the current memory-state visit.
  always_comb begin
    tmo_d = tmo_q;
    if (enter_mem_s) begin
      tmo_d = {TmoW{1'b0}};
    end else if (mem_state_s && !mem_ready) begin
      tmo_d = tmo_q + TmoW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= {TmoW{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_s;
  assign ready_s   = 1'b1;
  assign tmo_hit_s = 1'b0;
  assign unused_s  = mem_ready ^ (MEM_TIMEOUT < 1);
`endif

  // ALU operation for R/I-type; only R-type (opcode[5]=1) may select subtract.
  always_comb begin
    funct_alu_s = 3'b000;
    case (funct3)
      3'b000:  funct_alu_s = (funct7b5 && opcode[5]) ? 3'b001 : 3'b000;
      3'b010:  funct_alu_s = 3'b101;
      3'b110:  funct_alu_s = 3'b011;
      3'b111:  funct_alu_s = 3'b010;
      default: funct_alu_s = 3'b000;
    endcase
  end

  // Next state and sticky error code.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (ready_s) state_d = S_DECODE;
        else if (tmo_hit_s) begin state_d = S_TRAP; err_d = 2'b10; end
        else state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin state_d = S_TRAP; err_d = 2'b01; end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (ready_s) state_d = S_MEMWB;
        else if (tmo_hit_s) begin state_d = S_TRAP; err_d = 2'b10; end
        else state_d = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (ready_s) state_d = S_FETCH;
        else if (tmo_hit_s) begin state_d = S_TRAP; err_d = 2'b10; end
        else state_d = S_MEMWRITE;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  assign retire_s  = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                     ((state_q == S_MEMWRITE) && ready_s);
  assign instret_d = retire_s ? (instret_q + INSTRET_W'(1)) : instret_q;

  // Moore output values for the state being entered, registered alongside it.
  always_comb begin
    adr_src_d    = 1'b0;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    alu_ctrl_d   = 3'b000;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    case (state_d)
      S_FETCH:    begin alu_src_b_d = 2'b10; result_src_d = 2'b10; end
      S_DECODE:   begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
      S_MEMADR:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
      S_MEMREAD:  adr_src_d = 1'b1;
      S_MEMWB:    begin result_src_d = 2'b01; reg_write_d = 1'b1; end
      S_MEMWRITE: begin adr_src_d = 1'b1; mem_write_d = 1'b1; end
      S_EXECR:    begin alu_src_a_d = 2'b10; alu_ctrl_d = funct_alu_s; end
      S_EXECI:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; alu_ctrl_d = funct_alu_s; end
      S_ALUWB:    reg_write_d = 1'b1;
      S_BEQ:      begin alu_src_a_d = 2'b10; alu_ctrl_d = 3'b001; end
      S_JAL:      begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; end
      S_TRAP:     reg_write_d = 1'b0;
      default:    reg_write_d = 1'b0;
    endcase
  end

  // FSM state, error, retire counter and registered datapath controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      err_q        <= 2'b00;
      instret_q    <= {INSTRET_W{1'b0}};
      adr_src_q    <= 1'b0;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      result_src_q <= 2'b10;
      alu_ctrl_q   <= 3'b000;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      instret_q    <= instret_d;
      adr_src_q    <= adr_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      result_src_q <= result_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
    end
  end

  // ImmSrc follows the instruction register directly.
  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // The PC/IR enables carry the handshake and branch outcome; gated off during reset.
  assign PCWrite    = rst_n && (((state_q == S_FETCH) && ready_s) ||
                                ((state_q == S_BEQ) && zero) || (state_q == S_JAL));
  assign IRWrite    = rst_n && (state_q == S_FETCH) && ready_s;
  assign RegWrite   = reg_write_q;
  assign MemWrite   = mem_write_q;
  assign AdrSrc     = adr_src_q;
  assign ALUSrcA    = alu_src_a_q;
  assign ALUSrcB    = alu_src_b_q;
  assign ResultSrc  = result_src_q;
  assign ALUControl = alu_ctrl_q;
  assign state      = state_q;
  assign err        = err_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level reference model pushes per-cycle
// expectations; a negedge monitor pops and compares. Works with or without MEM_HANDSHAKE_EN.
module tb_multicycle_control_unit;

  localparam int MT = 4;
  localparam int IW = 4;
`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 15;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  logic          clk, rst_n;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5, zero, mem_ready;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, err;
  logic [2:0]    ALUControl;
  logic [3:0]    state;
  logic [IW-1:0] instret;

  multicycle_control_unit #(.MEM_TIMEOUT(MT), .INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state(state), .err(err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 in a field means the specification leaves that output free in this state.
  typedef struct {
    int st; int pcw; int irw; int rw; int mw; int adr; int a; int b; int rs; int alu;
    int imm; int err; int ins;
  } exp_t;

  exp_t       sb_q[$];
  int         m_err, m_ins;
  int         n_pass, n_total;
  logic [6:0] nxt_op;
  logic [2:0] nxt_f3;
  logic       nxt_f7;

  function automatic int imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 1;
    else if (op == 7'b1100011) return 2;
    else if (op == 7'b1101111) return 3;
    else return 0;
  endfunction

  function automatic int alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (f7 && op == 7'b0110011) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] ill_op(input int i);
    case (i % 4)
      0:       return 7'b1111111;
      1:       return 7'b0110111;
      2:       return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    if (want >= 0) begin
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, want);
    end
  endtask

  // One clock cycle spent in state st with the given memory/zero inputs.
  task automatic cyc(input int st, input bit rdy, input bit z, input bit retire);
    exp_t e;
    bit   eff;
    @(posedge clk);
    #1;
    rst_n = 1'b1; mem_ready = rdy; zero = z;
    opcode = nxt_op; funct3 = nxt_f3; funct7b5 = nxt_f7;
    eff = HS ? rdy : 1'b1;
    e.st = st; e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0;
    e.adr = -1; e.a = -1; e.b = -1; e.rs = -1; e.alu = -1;
    e.imm = imm_of(opcode); e.err = m_err; e.ins = m_ins;
    case (st)
      FETCH:    begin e.pcw = eff; e.irw = eff; e.adr = 0; e.a = 0; e.b = 2; e.alu = 0; e.rs = 2; end
      DECODE:   begin e.a = 1; e.b = 1; e.alu = 0; end
      MEMADR:   begin e.a = 2; e.b = 1; e.alu = 0; end
      MEMREAD:  begin e.adr = 1; e.rs = 0; end
      MEMWB:    begin e.rs = 1; e.rw = 1; end
      MEMWRITE: begin e.adr = 1; e.rs = 0; e.mw = 1; end
      EXECR:    begin e.a = 2; e.b = 0; e.alu = alu_of(opcode, funct3, funct7b5); end
      EXECI:    begin e.a = 2; e.b = 1; e.alu = alu_of(opcode, funct3, funct7b5); end
      ALUWB:    begin e.rs = 0; e.rw = 1; end
      BEQ:      begin e.a = 2; e.b = 0; e.alu = 1; e.rs = 0; e.pcw = z; end
      JAL:      begin e.a = 1; e.b = 2; e.alu = 0; e.rs = 0; e.pcw = 1; end
      default:  e.st = st;
    endcase
    sb_q.push_back(e);
    if (retire) m_ins = (m_ins + 1) % (1 << IW);
  endtask

  task automatic do_reset();
    exp_t e;
    m_err = 0; m_ins = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0; mem_ready = 1'($urandom); zero = 1'($urandom);
      e.st = FETCH; e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; e.adr = 0; e.a = 0; e.b = 2;
      e.rs = 2; e.alu = 0; e.imm = imm_of(opcode); e.err = 0; e.ins = 0;
      sb_q.push_back(e);
    end
  endtask

  task automatic trap_tail(input int code);
    m_err = code;
    repeat (20) cyc(TRAP, 1'($urandom), 1'($urandom), 1'b0);
    do_reset();
  endtask

  // A memory state: `waits` not-ready cycles, trapping once MT of them have elapsed.
  task automatic mem_wait(input int st, input int waits, input bit ret, output bit trapped);
    int w;
    w = HS ? waits : 0;
    trapped = 1'b0;
    for (int k = 0; k < w && k < MT; k++) cyc(st, 1'b0, 1'($urandom), 1'b0);
    if (w >= MT) trapped = 1'b1;
    else cyc(st, HS ? 1'b1 : 1'($urandom), 1'($urandom), ret);
  endtask

  task automatic run_instr(input int kind, input logic [2:0] f3, input bit f7,
                           input int wf, input int wm, input bit bz);
    bit tr;
    mem_wait(FETCH, wf, 1'b0, tr);
    if (tr) begin trap_tail(2); return; end
    nxt_f3 = f3; nxt_f7 = f7;
    case (kind)
      K_LW:    nxt_op = 7'b0000011;
      K_SW:    nxt_op = 7'b0100011;
      K_R:     nxt_op = 7'b0110011;
      K_I:     nxt_op = 7'b0010011;
      K_BEQ:   nxt_op = 7'b1100011;
      K_JAL:   nxt_op = 7'b1101111;
      default: nxt_op = ill_op(int'(f3));
    endcase
    cyc(DECODE, 1'($urandom), 1'($urandom), 1'b0);
    case (kind)
      K_LW: begin
        cyc(MEMADR, 1'($urandom), 1'($urandom), 1'b0);
        mem_wait(MEMREAD, wm, 1'b0, tr);
        if (tr) trap_tail(2);
        else cyc(MEMWB, 1'($urandom), 1'($urandom), 1'b1);
      end
      K_SW: begin
        cyc(MEMADR, 1'($urandom), 1'($urandom), 1'b0);
        mem_wait(MEMWRITE, wm, 1'b1, tr);
        if (tr) trap_tail(2);
      end
      K_R:   begin cyc(EXECR, 1'($urandom), 1'($urandom), 1'b0); cyc(ALUWB, 1'($urandom), 1'($urandom), 1'b1); end
      K_I:   begin cyc(EXECI, 1'($urandom), 1'($urandom), 1'b0); cyc(ALUWB, 1'($urandom), 1'($urandom), 1'b1); end
      K_BEQ: cyc(BEQ, 1'($urandom), bz, 1'b1);
      K_JAL: begin cyc(JAL, 1'($urandom), 1'($urandom), 1'b0); cyc(ALUWB, 1'($urandom), 1'($urandom), 1'b1); end
      default: trap_tail(1);
    endcase
  endtask

  // lw abandoned by reset before it reaches write-back.
  task automatic abort_lw();
    bit tr;
    mem_wait(FETCH, 0, 1'b0, tr);
    nxt_op = 7'b0000011;
    cyc(DECODE, 1'($urandom), 1'($urandom), 1'b0);
    cyc(MEMADR, 1'($urandom), 1'($urandom), 1'b0);
    do_reset();
  endtask

  function automatic int rand_waits();
    if ($urandom_range(0, 9) == 0) return $urandom_range(MT - 1, MT + 2);
    return $urandom_range(0, 2);
  endfunction

  // Monitor: every cycle that has an expectation is compared at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("state",      int'(state),      e.st);
      chk("PCWrite",    int'(PCWrite),    e.pcw);
      chk("IRWrite",    int'(IRWrite),    e.irw);
      chk("RegWrite",   int'(RegWrite),   e.rw);
      chk("MemWrite",   int'(MemWrite),   e.mw);
      chk("AdrSrc",     int'(AdrSrc),     e.adr);
      chk("ALUSrcA",    int'(ALUSrcA),    e.a);
      chk("ALUSrcB",    int'(ALUSrcB),    e.b);
      chk("ResultSrc",  int'(ResultSrc),  e.rs);
      chk("ALUControl", int'(ALUControl), e.alu);
      chk("ImmSrc",     int'(ImmSrc),     e.imm);
      chk("err",        int'(err),        e.err);
      chk("instret",    int'(instret),    e.ins);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int guard;
    n_pass = 0; n_total = 0; m_err = 0; m_ins = 0;
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    nxt_op = 7'd0; nxt_f3 = 3'd0; nxt_f7 = 1'b0;
    do_reset();

    run_instr(K_LW,  3'd0, 1'b0, 0, 0, 1'b0);
    run_instr(K_SW,  3'd2, 1'b0, 0, 3, 1'b0);
    run_instr(K_R,   3'd0, 1'b1, 0, 0, 1'b0);
    run_instr(K_I,   3'd0, 1'b1, 0, 0, 1'b0);
    run_instr(K_BEQ, 3'd0, 1'b0, 0, 0, 1'b1);
    run_instr(K_BEQ, 3'd0, 1'b0, 0, 0, 1'b0);
    run_instr(K_JAL, 3'd0, 1'b0, 0, 0, 1'b0);
    run_instr(K_ILL, 3'd0, 1'b0, 0, 0, 1'b0);
    abort_lw();
    run_instr(K_R,   3'd6, 1'b0, MT,     0, 1'b0);
    run_instr(K_R,   3'd7, 1'b0, MT - 1, 0, 1'b0);
    run_instr(K_LW,  3'd0, 1'b0, 0, MT, 1'b0);
    run_instr(K_SW,  3'd0, 1'b0, 0, MT - 1, 1'b0);

    repeat (300) begin
      kind = $urandom_range(0, 19);
      if (kind < 4)       run_instr(K_LW,  3'($urandom), 1'($urandom), rand_waits(), rand_waits(), 1'($urandom));
      else if (kind < 7)  run_instr(K_SW,  3'($urandom), 1'($urandom), rand_waits(), rand_waits(), 1'($urandom));
      else if (kind < 11) run_instr(K_R,   3'($urandom), 1'($urandom), rand_waits(), 0, 1'($urandom));
      else if (kind < 14) run_instr(K_I,   3'($urandom), 1'($urandom), rand_waits(), 0, 1'($urandom));
      else if (kind < 17) run_instr(K_BEQ, 3'($urandom), 1'($urandom), rand_waits(), 0, 1'($urandom));
      else if (kind < 19) run_instr(K_JAL, 3'($urandom), 1'($urandom), rand_waits(), 0, 1'($urandom));
      else if ($urandom_range(0, 1) == 0) run_instr(K_ILL, 3'($urandom), 1'($urandom), 0, 0, 1'b0);
      else abort_lw();
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
